// File: rtl/osd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : osd_arbiter
//  Description : Frame-synchronous arbiter between the ASCII file-browser OSD
//                and the MCU (u8g2) OSD layer. Ownership changes only on a
//                frame tick derived from vsync; every change of owner passes
//                through one blanked handover frame. An idle owner is revoked
//                after TIMEOUT_FRAMES frames without activity and is locked
//                out until it drops its request.
//
//  Parameters  : TIMEOUT_FRAMES - inactivity limit in frames, 0 = no timeout
//                                 (must be < 2**CNT_W)
//                CNT_W          - width of the inactivity frame counter
//
//  Ports       : clk      in   pixel clock
//                resetn   in   asynchronous active-low reset
//                vs_n     in   scandoubled vsync, active low, asynchronous
//                req_a    in   ASCII OSD requests the screen (level)
//                req_m    in   MCU OSD requests the screen (level)
//                act_a    in   ASCII activity pulse, one clk
//                act_m    in   MCU activity pulse, one clk
//                gnt_a    out  ASCII layer visible
//                gnt_m    out  MCU layer visible
//                blank    out  handover frame, both layers hidden
//                owner    out  00 none, 01 ASCII, 10 MCU, 11 handover
//                timeout  out  one-clk pulse when the owner is revoked
//
//  Revision    : 1.0 - initial release
// ============================================================================
module osd_arbiter #(
    parameter int TIMEOUT_FRAMES = 250,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       vs_n,
    input  logic       req_a,
    input  logic       req_m,
    input  logic       act_a,
    input  logic       act_m,
    output logic       gnt_a,
    output logic       gnt_m,
    output logic       blank,
    output logic [1:0] owner,
    output logic       timeout
);

    // State encoding equals the owner code, so owner is the state register.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_GNT_A    = 2'b01,
        ST_GNT_M    = 2'b10,
        ST_HANDOVER = 2'b11
    } state_t;

    localparam bit             c_TO_EN   = (TIMEOUT_FRAMES != 0);
    localparam logic [CNT_W-1:0] c_TO_LAST =
        (TIMEOUT_FRAMES == 0) ? '0 : CNT_W'(TIMEOUT_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // ------------------------------------------------------------------
    // vsync synchronizer and falling-edge detector
    // ------------------------------------------------------------------
    // Flops reset to 1 so that releasing reset with vsync high never looks
    // like a falling edge.
    logic r_vs_meta;
    logic r_vs_sync;
    logic r_vs_prev;
    logic w_frame_tick;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vs_meta <= 1'b1;
            r_vs_sync <= 1'b1;
            r_vs_prev <= 1'b1;
        end else begin
            r_vs_meta <= vs_n;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    // Built only from flop outputs, so it is a clean one-clk pulse. The state
    // register and the outputs update on the edge that closes this pulse,
    // i.e. the third clk edge after vs_n is first sampled low.
    assign w_frame_tick = r_vs_prev & ~r_vs_sync;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_lock_a;
    logic               r_lock_m;
    logic               r_gnt_a;
    logic               r_gnt_m;
    logic               r_blank;
    logic               r_timeout;

    logic w_in_gnt;
    logic w_owner_act;
    logic w_elig_a;
    logic w_elig_m;
    logic w_timeout;

    assign w_in_gnt    = (r_state == ST_GNT_A) || (r_state == ST_GNT_M);
    // Only the current owner's activity keeps it alive.
    assign w_owner_act = ((r_state == ST_GNT_A) && act_a) ||
                         ((r_state == ST_GNT_M) && act_m);
    assign w_elig_a    = req_a & ~r_lock_a;
    assign w_elig_m    = req_m & ~r_lock_m;
    // Activity on the tick edge counts as a counter clear, which beats expiry.
    assign w_timeout   = c_TO_EN && w_frame_tick && w_in_gnt &&
                         (r_cnt == c_TO_LAST) && !w_owner_act;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_frame_tick) begin
            case (r_state)
                ST_IDLE, ST_HANDOVER: begin
                    // MCU has priority over ASCII when both are eligible.
                    if (w_elig_m) begin
                        w_state_next = ST_GNT_M;
                    end else if (w_elig_a) begin
                        w_state_next = ST_GNT_A;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_GNT_A: begin
                    if (!req_a || w_timeout || w_elig_m) begin
                        w_state_next = ST_HANDOVER;
                    end
                end
                ST_GNT_M: begin
                    // ASCII never preempts the MCU layer.
                    if (!req_m || w_timeout) begin
                        w_state_next = ST_HANDOVER;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Inactivity counter: zero outside a grant (hence zero on entry to one),
    // cleared by owner activity, counts ticks and saturates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (!w_in_gnt || w_owner_act) begin
            r_cnt <= '0;
        end else if (c_TO_EN && w_frame_tick && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A revoked owner stays ineligible until its request is seen low.
    // Setting has priority; a simultaneously low request clears it next clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lock_a <= 1'b0;
            r_lock_m <= 1'b0;
        end else begin
            if (!req_a) begin
                r_lock_a <= 1'b0;
            end
            if (!req_m) begin
                r_lock_m <= 1'b0;
            end
            if (w_timeout && (r_state == ST_GNT_A)) begin
                r_lock_a <= 1'b1;
            end
            if (w_timeout && (r_state == ST_GNT_M)) begin
                r_lock_m <= 1'b1;
            end
        end
    end

    // Registered decodes of the next state keep the grant lines glitch-free
    // and exactly in step with owner.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_gnt_a   <= 1'b0;
            r_gnt_m   <= 1'b0;
            r_blank   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_gnt_a   <= (w_state_next == ST_GNT_A);
            r_gnt_m   <= (w_state_next == ST_GNT_M);
            r_blank   <= (w_state_next == ST_HANDOVER);
            r_timeout <= w_timeout;
        end
    end

    assign gnt_a   = r_gnt_a;
    assign gnt_m   = r_gnt_m;
    assign blank   = r_blank;
    assign owner   = r_state;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_osd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_osd_arbiter
//  Description : Directed self-checking bench for osd_arbiter. Main instance
//                uses TIMEOUT_FRAMES=4; a second instance with the timeout
//                disabled shares the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_arbiter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       vs_n;
    logic       req_a;
    logic       req_m;
    logic       act_a;
    logic       act_m;
    logic       gnt_a;
    logic       gnt_m;
    logic       blank;
    logic [1:0] owner;
    logic       timeout;

    logic       z_gnt_a;
    logic       z_gnt_m;
    logic       z_blank;
    logic [1:0] z_owner;
    logic       z_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    osd_arbiter #(
        .TIMEOUT_FRAMES (4),
        .CNT_W          (8)
    ) u_dut (
        .clk     (clk),
        .resetn  (resetn),
        .vs_n    (vs_n),
        .req_a   (req_a),
        .req_m   (req_m),
        .act_a   (act_a),
        .act_m   (act_m),
        .gnt_a   (gnt_a),
        .gnt_m   (gnt_m),
        .blank   (blank),
        .owner   (owner),
        .timeout (timeout)
    );

    osd_arbiter #(
        .TIMEOUT_FRAMES (0),
        .CNT_W          (8)
    ) u_dut_noto (
        .clk     (clk),
        .resetn  (resetn),
        .vs_n    (vs_n),
        .req_a   (req_a),
        .req_m   (req_m),
        .act_a   (act_a),
        .act_m   (act_m),
        .gnt_a   (z_gnt_a),
        .gnt_m   (z_gnt_m),
        .blank   (z_blank),
        .owner   (z_owner),
        .timeout (z_timeout)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All outputs of the main instance against an expected owner code.
    task automatic check_outs(input string tag, input logic [1:0] exp_owner, input logic exp_to);
        check({tag, ".owner"},   {6'd0, owner},   {6'd0, exp_owner});
        check({tag, ".gnt_a"},   {7'd0, gnt_a},   {7'd0, (exp_owner == 2'b01)});
        check({tag, ".gnt_m"},   {7'd0, gnt_m},   {7'd0, (exp_owner == 2'b10)});
        check({tag, ".blank"},   {7'd0, blank},   {7'd0, (exp_owner == 2'b11)});
        check({tag, ".timeout"}, {7'd0, timeout}, {7'd0, exp_to});
    endtask

    // One frame: vsync idle high, then a fall. Optional activity pulses are
    // placed on the clk edge that applies the tick. Returns at the negedge
    // right after that edge.
    task automatic tick(input logic pa, input logic pm);
        repeat (4) @(negedge clk);
        vs_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        act_a = pa;
        act_m = pm;
        @(negedge clk);
        act_a = 1'b0;
        act_m = 1'b0;
        vs_n  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        vs_n   = 1'b1;
        req_a  = 1'b0;
        req_m  = 1'b0;
        act_a  = 1'b0;
        act_m  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_outs("reset", 2'b00, 1'b0);
        check("reset.noto_owner", {6'd0, z_owner}, 8'd0);

        // ASCII requests at release; no tick without a vsync fall
        req_a  = 1'b1;
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        check_outs("release_no_tick", 2'b00, 1'b0);

        // Grant appears on the 3rd clk after vs_n is first sampled low
        vs_n = 1'b0;
        @(negedge clk);
        check_outs("first_e1", 2'b00, 1'b0);
        @(negedge clk);
        check_outs("first_e2", 2'b00, 1'b0);
        @(negedge clk);
        check_outs("first_e3", 2'b01, 1'b0);
        vs_n = 1'b1;

        // Release -> one handover frame -> idle
        req_a = 1'b0;
        tick(1'b0, 1'b0);
        check_outs("release_ho", 2'b11, 1'b0);
        tick(1'b0, 1'b0);
        check_outs("release_idle", 2'b00, 1'b0);

        // MCU preempts ASCII; ASCII cannot take it back
        req_a = 1'b1;
        tick(1'b0, 1'b0);
        check_outs("pre_gnt_a", 2'b01, 1'b0);
        req_m = 1'b1;
        tick(1'b0, 1'b0);
        check_outs("pre_ho", 2'b11, 1'b0);
        tick(1'b0, 1'b0);
        check_outs("pre_gnt_m", 2'b10, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick(1'b0, 1'b0);
            check_outs($sformatf("hold_m%0d", i), 2'b10, 1'b0);
        end

        // Owner activity on the expiring tick clears the counter
        tick(1'b0, 1'b1);
        check_outs("act_saves", 2'b10, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick(1'b0, 1'b0);
            check_outs($sformatf("after_act%0d", i), 2'b10, 1'b0);
        end

        // Fourth silent tick revokes the MCU
        tick(1'b0, 1'b0);
        check_outs("to_m", 2'b11, 1'b1);
        check("to_m.noto_owner", {6'd0, z_owner}, 8'd2);
        check("to_m.noto_timeout", {7'd0, z_timeout}, 8'd0);
        @(negedge clk);
        check("to_m.pulse_end", {7'd0, timeout}, 8'd0);

        // Locked MCU is ineligible, ASCII takes over and is not preempted
        tick(1'b0, 1'b0);
        check_outs("lock_m_gnt_a", 2'b01, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            tick(1'b1, 1'b0);
            check_outs($sformatf("lock_m_hold%0d", i), 2'b01, 1'b0);
        end

        // Dropping req_m for one clk clears the lock
        req_m = 1'b0;
        @(negedge clk);
        req_m = 1'b1;
        tick(1'b1, 1'b0);
        check_outs("unlock_m_ho", 2'b11, 1'b0);
        tick(1'b0, 1'b0);
        check_outs("unlock_m_gnt", 2'b10, 1'b0);

        // Back to ASCII; MCU pulses do not keep ASCII alive
        req_m = 1'b0;
        tick(1'b0, 1'b0);
        check_outs("to_a_ho", 2'b11, 1'b0);
        tick(1'b0, 1'b0);
        check_outs("to_a_gnt", 2'b01, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick(1'b0, 1'b1);
            check_outs($sformatf("nonowner_act%0d", i), 2'b01, 1'b0);
        end
        tick(1'b0, 1'b1);
        check_outs("to_a", 2'b11, 1'b1);
        tick(1'b0, 1'b0);
        check_outs("lock_a_idle", 2'b00, 1'b0);
        tick(1'b0, 1'b0);
        check_outs("lock_a_still", 2'b00, 1'b0);
        req_a = 1'b0;
        @(negedge clk);
        req_a = 1'b1;
        tick(1'b0, 1'b0);
        check_outs("unlock_a_gnt", 2'b01, 1'b0);

        // Simultaneous requests from idle: MCU wins directly
        req_a = 1'b0;
        tick(1'b0, 1'b0);
        check_outs("sim_ho", 2'b11, 1'b0);
        tick(1'b0, 1'b0);
        check_outs("sim_idle", 2'b00, 1'b0);
        req_a = 1'b1;
        req_m = 1'b1;
        tick(1'b0, 1'b0);
        check_outs("sim_gnt_m", 2'b10, 1'b0);

        // Asynchronous reset mid-frame while MCU owns the screen
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_outs("async_rst", 2'b00, 1'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        check_outs("post_rst_no_tick", 2'b00, 1'b0);
        tick(1'b0, 1'b0);
        check_outs("post_rst_gnt", 2'b10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
